spi_command_decoder: RTL and testbench
======================================

# spi_command_decoder

Synchronous, parametrised command decoder between the SPI byte receiver and the core's register/memory bus. It assembles opcode, address and value bytes into bus transactions and issues WRITE, READ, STREAM (burst write with auto-incrementing address), TRANSFER (read-back byte shift-out) and REPEAT (re-issue last command). It adds an inter-byte timeout so a truncated frame cannot wedge the decoder. Address and value widths are generic multiples of 8.

## Interface
- ADDRESS_WIDTH, 24, address bus width; multiple of 8; AB = ADDRESS_WIDTH/8 address bytes.
- VALUE_WIDTH, 32, value bus width; multiple of 8; VB = VALUE_WIDTH/8 value bytes.
- INSTRUCTION_WIDTH, 8, instruction bus width; opcode zero-extended into it.
- TIMEOUT_CYCLES, 1024, idle clocks between bytes before a frame is aborted; ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- spi_rx_valid  in  1  one-cycle strobe, spi_rx_byte valid.
- spi_rx_byte  in  8  received byte.
- value_from_core  in  VALUE_WIDTH  read data; valid during the cycle cmd_valid is high for a READ.
- instruction_bus  out  INSTRUCTION_WIDTH  opcode of issued command (WRITE or READ only).
- address_bus  out  ADDRESS_WIDTH  command address.
- value_bus  out  VALUE_WIDTH  write data; 0 for READ.
- cmd_valid  out  1  one-cycle pulse, buses hold a new command.
- tx_byte  out  8  byte for the SPI transmitter.
- tx_load  out  1  one-cycle pulse, tx_byte updated.
- busy  out  1  high whenever state ≠ IDLE.
- error  out  1  one-cycle pulse on unknown opcode or timeout.

## Operation
- Opcodes: 0x01 WRITE, 0x02 READ, 0x03 STREAM, 0x04 TRANSFER, 0x05 REPEAT; all others unknown. Multi-byte fields are MSB first.
- States: IDLE, ADDR, LEN, DATA.
- IDLE, byte 0x01/0x02/0x03: latch opcode, clear byte counter, go to ADDR.
- IDLE, byte 0x04: load tx_byte with read buffer byte [rd_ptr] (byte 0 = MSB), pulse tx_load, rd_ptr increments and wraps from VB-1 to 0. Stay IDLE.
- IDLE, byte 0x05: if a command has been issued since reset, re-pulse cmd_valid with the unchanged buses. A repeated READ re-captures into the read buffer. Otherwise ignore. Stay IDLE.
- IDLE, unknown byte: pulse error; stay IDLE.
- ADDR: shift AB bytes into the address register.
  - After the last byte: WRITE → DATA; READ → issue command, → IDLE; STREAM → LEN.
- LEN (STREAM only): one byte gives the word count N; 0x00 means 256. → DATA.
- DATA: shift VB bytes into the value register. After the last byte, issue a WRITE.
  - WRITE → IDLE.
  - STREAM: the address register increments by 1, modulo 2^ADDRESS_WIDTH, after each issued word. Decrement the remaining count; → IDLE after word N, else stay in DATA.
- STREAM words are issued on instruction_bus as WRITE (0x01).
- READ issue: value_bus = 0. value_from_core is captured into the read buffer on the clock edge ending the cmd_valid cycle; rd_ptr resets to 0.
- Opcode bytes received outside IDLE are treated as data.
- Timeout: a counter runs while state ≠ IDLE and clears on every spi_rx_valid. On reaching TIMEOUT_CYCLES: pulse error, go to IDLE, and drop the partial frame.
  - STREAM words already issued stand.
  - The bus outputs are not changed.

## Timing
- Reset (async assert, sync-safe release):
  - State IDLE.
  - instruction_bus, address_bus, value_bus, tx_byte, read buffer, and all counters = 0.
  - cmd_valid, tx_load, busy, error = 0.
  - "command issued" flag cleared.
- Reset mid-frame aborts without issuing.
- cmd_valid and the bus update happen on the edge after the final byte's spi_rx_valid cycle (1-cycle latency). The buses hold until the next issue.
- tx_load is asserted 1 cycle after the TRANSFER byte's strobe.
- error is asserted 1 cycle after the unknown byte, or in the cycle the timeout counter reaches TIMEOUT_CYCLES.
- spi_rx_valid and timeout expiry in the same cycle: the byte wins, the counter clears, and no error.
- Back-to-back spi_rx_valid on consecutive cycles is supported; every strobe is consumed.
- A READ followed by TRANSFER on the next cycle returns the newly captured data.
- busy rises the cycle after the opcode strobe and falls the cycle after the final byte.

## Test plan
- WRITE: bytes 01 12 34 56 DE AD BE EF → one cmd_valid pulse; instruction_bus=0x01, address_bus=0x123456, value_bus=0xDEADBEEF; busy low afterwards.
- READ then TRANSFER: 02 00 00 10 with value_from_core=0xCAFEF00D in the cmd_valid cycle → cmd_valid with address 0x000010, value_bus=0. Then 04 ×5 → tx_byte CA, FE, F0, 0D, CA, each with a tx_load pulse.
- STREAM with address wrap: 03 FF FF FF 02, then 00000001 and 00000002 → two cmd_valid pulses at addresses 0xFFFFFF and 0x000000 with values 1 and 2, opcode 0x01.
- REPEAT: 05 right after reset → no cmd_valid. After the WRITE scenario, 05 → one more cmd_valid with identical buses.
- Timeout: 01 12 34 then silence for TIMEOUT_CYCLES → error pulse, busy low, no cmd_valid. A subsequent complete WRITE decodes correctly.
- Unknown opcode 0x07 → error pulse, state IDLE. rst_n low mid-DATA → all outputs 0 immediately, no issue.

Source files
------------

// File: rtl/spi_command_decoder.sv
// SPI command decoder: assembles received bytes into bus transactions.
// Supports WRITE, READ, STREAM, TRANSFER and REPEAT with inter-byte timeout.
module spi_command_decoder #(
    parameter int ADDRESS_WIDTH     = 24,
    parameter int VALUE_WIDTH       = 32,
    parameter int INSTRUCTION_WIDTH = 8,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_rx_valid,
    input  logic [7:0]                   spi_rx_byte,
    input  logic [VALUE_WIDTH-1:0]       value_from_core,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_bus,
    output logic [ADDRESS_WIDTH-1:0]     address_bus,
    output logic [VALUE_WIDTH-1:0]       value_bus,
    output logic                         cmd_valid,
    output logic [7:0]                   tx_byte,
    output logic                         tx_load,
    output logic                         busy,
    output logic                         error
);

    localparam int AB   = ADDRESS_WIDTH / 8;
    localparam int VB   = VALUE_WIDTH / 8;
    localparam int MAXB = (AB > VB) ? AB : VB;
    localparam int BCW  = $clog2(MAXB + 1);
    localparam int PW   = (VB > 1) ? $clog2(VB) : 1;
    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_READ     = 8'h02;
    localparam logic [7:0] OP_STREAM   = 8'h03;
    localparam logic [7:0] OP_TRANSFER = 8'h04;
    localparam logic [7:0] OP_REPEAT   = 8'h05;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LEN,
        DATA
    } state_t;

    state_t                   state;
    logic [7:0]               opcode;
    logic [BCW-1:0]           byte_cnt;
    logic [ADDRESS_WIDTH-1:0] addr_reg;
    logic [VALUE_WIDTH-1:0]   value_reg;
    logic [8:0]               words_left;
    logic [TW-1:0]            tmo_cnt;
    logic [VALUE_WIDTH-1:0]   rd_buf;
    logic [PW-1:0]            rd_ptr;
    logic                     issued;

    logic                     capture;
    logic [VALUE_WIDTH-1:0]   buf_eff;
    logic [PW-1:0]            ptr_eff;
    logic [PW-1:0]            ptr_next;
    logic [VALUE_WIDTH-1:0]   shifted;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [VALUE_WIDTH-1:0]   value_next;
    logic                     last_addr;
    logic                     last_val;

    assign busy = (state != IDLE);

    // Read-buffer bypass so a TRANSFER in the READ issue cycle sees fresh data.
    always_comb begin
        capture    = cmd_valid &&
                     (instruction_bus == INSTRUCTION_WIDTH'(OP_READ));
        buf_eff    = capture ? value_from_core : rd_buf;
        ptr_eff    = capture ? '0 : rd_ptr;
        ptr_next   = (ptr_eff == PW'(VB - 1)) ? '0 : ptr_eff + 1'b1;
        shifted    = buf_eff << {ptr_eff, 3'b000};
        addr_next  = (addr_reg << 8) | ADDRESS_WIDTH'(spi_rx_byte);
        value_next = (value_reg << 8) | VALUE_WIDTH'(spi_rx_byte);
        last_addr  = (byte_cnt == BCW'(AB - 1));
        last_val   = (byte_cnt == BCW'(VB - 1));
    end

    // Frame decoder FSM with registered bus, transmit and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            opcode          <= '0;
            byte_cnt        <= '0;
            addr_reg        <= '0;
            value_reg       <= '0;
            words_left      <= '0;
            tmo_cnt         <= '0;
            rd_buf          <= '0;
            rd_ptr          <= '0;
            issued          <= 1'b0;
            instruction_bus <= '0;
            address_bus     <= '0;
            value_bus       <= '0;
            cmd_valid       <= 1'b0;
            tx_byte         <= '0;
            tx_load         <= 1'b0;
            error           <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            tx_load   <= 1'b0;
            error     <= 1'b0;
            if (capture) begin
                rd_buf <= value_from_core;
                rd_ptr <= '0;
            end
            if (spi_rx_valid) begin
                tmo_cnt <= '0;
                unique case (state)
                    IDLE: begin
                        case (spi_rx_byte)
                            OP_WRITE, OP_READ, OP_STREAM: begin
                                opcode   <= spi_rx_byte;
                                byte_cnt <= '0;
                                state    <= ADDR;
                            end
                            OP_TRANSFER: begin
                                tx_byte <= shifted[VALUE_WIDTH-1 -: 8];
                                tx_load <= 1'b1;
                                rd_buf  <= buf_eff;
                                rd_ptr  <= ptr_next;
                            end
                            OP_REPEAT: begin
                                if (issued) cmd_valid <= 1'b1;
                            end
                            default: error <= 1'b1;
                        endcase
                    end
                    ADDR: begin
                        addr_reg <= addr_next;
                        byte_cnt <= byte_cnt + 1'b1;
                        if (last_addr) begin
                            byte_cnt <= '0;
                            if (opcode == OP_READ) begin
                                instruction_bus <=
                                    INSTRUCTION_WIDTH'(OP_READ);
                                address_bus <= addr_next;
                                value_bus   <= '0;
                                cmd_valid   <= 1'b1;
                                issued      <= 1'b1;
                                state       <= IDLE;
                            end else if (opcode == OP_WRITE) begin
                                state <= DATA;
                            end else begin
                                state <= LEN;
                            end
                        end
                    end
                    LEN: begin
                        words_left <= (spi_rx_byte == 8'h00) ?
                                      9'd256 : {1'b0, spi_rx_byte};
                        byte_cnt   <= '0;
                        state      <= DATA;
                    end
                    DATA: begin
                        value_reg <= value_next;
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (last_val) begin
                            byte_cnt        <= '0;
                            instruction_bus <= INSTRUCTION_WIDTH'(OP_WRITE);
                            address_bus     <= addr_reg;
                            value_bus       <= value_next;
                            cmd_valid       <= 1'b1;
                            issued          <= 1'b1;
                            if (opcode == OP_STREAM) begin
                                addr_reg   <= addr_reg + 1'b1;
                                words_left <= words_left - 1'b1;
                                if (words_left == 9'd1) state <= IDLE;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                endcase
            end else if (state != IDLE) begin
                if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    error   <= 1'b1;
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_command_decoder.sv
// Bench for spi_command_decoder: directed scenarios plus random frames
// checked against a frame-level reference model.
module tb_spi_command_decoder;

    localparam int AW = 24;
    localparam int VW = 32;
    localparam int AB = AW / 8;
    localparam int VB = VW / 8;
    localparam int T  = 40;

    typedef struct {
        logic [7:0]    instr;
        logic [AW-1:0] addr;
        logic [VW-1:0] val;
    } cmd_t;

    logic          clk;
    logic          rst_n;
    logic          spi_rx_valid;
    logic [7:0]    spi_rx_byte;
    logic [VW-1:0] value_from_core;
    logic [7:0]    instruction_bus;
    logic [AW-1:0] address_bus;
    logic [VW-1:0] value_bus;
    logic          cmd_valid;
    logic [7:0]    tx_byte;
    logic          tx_load;
    logic          busy;
    logic          error;

    int total = 0;
    int bad   = 0;

    cmd_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         exp_err  = 0;
    int         err_seen = 0;

    bit         m_busy = 0;
    logic [7:0] m_op;
    logic [7:0] m_q[$];
    int         m_words;
    logic [VW-1:0] m_buf = '0;
    int         m_ptr = 0;
    bit         m_have = 0;
    cmd_t       m_last;

    spi_command_decoder #(
        .ADDRESS_WIDTH(AW),
        .VALUE_WIDTH(VW),
        .INSTRUCTION_WIDTH(8),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi_rx_valid(spi_rx_valid),
        .spi_rx_byte(spi_rx_byte),
        .value_from_core(value_from_core),
        .instruction_bus(instruction_bus),
        .address_bus(address_bus),
        .value_bus(value_bus),
        .cmd_valid(cmd_valid),
        .tx_byte(tx_byte),
        .tx_load(tx_load),
        .busy(busy),
        .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VW-1:0] core_fn(input logic [AW-1:0] a);
        if (a == 24'h000010) return 32'hCAFEF00D;
        return {a[7:0], a[15:8] ^ 8'hA5, a[23:16], a[7:0] ^ 8'h3C};
    endfunction

    assign value_from_core = core_fn(address_bus);

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] field(input int start, input int n);
        logic [63:0] acc = '0;
        for (int i = 0; i < n; i++) acc = (acc << 8) | 64'(m_q[start + i]);
        return acc;
    endfunction

    function automatic void mdl_issue(input cmd_t c);
        exp_q.push_back(c);
        m_last = c;
        m_have = 1;
        if (c.instr == 8'h02) begin
            m_buf = core_fn(c.addr);
            m_ptr = 0;
        end
    endfunction

    function automatic void mdl_byte(input logic [7:0] b);
        cmd_t c;
        int n;
        int k;
        if (!m_busy) begin
            if (b == 8'h01 || b == 8'h02 || b == 8'h03) begin
                m_op = b;
                m_q.delete();
                m_busy = 1;
            end else if (b == 8'h04) begin
                tx_q.push_back(8'(m_buf >> (8 * (VB - 1 - m_ptr))));
                m_ptr = (m_ptr + 1) % VB;
            end else if (b == 8'h05) begin
                if (m_have) mdl_issue(m_last);
            end else begin
                exp_err++;
            end
            return;
        end
        m_q.push_back(b);
        n = m_q.size();
        if (m_op == 8'h02 && n == AB) begin
            c.instr = 8'h02;
            c.addr  = AW'(field(0, AB));
            c.val   = '0;
            mdl_issue(c);
            m_busy = 0;
        end else if (m_op == 8'h01 && n == AB + VB) begin
            c.instr = 8'h01;
            c.addr  = AW'(field(0, AB));
            c.val   = VW'(field(AB, VB));
            mdl_issue(c);
            m_busy = 0;
        end else if (m_op == 8'h03) begin
            if (n == AB + 1) begin
                m_words = (b == 8'h00) ? 256 : int'(b);
            end else if (n > AB + 1 && (n - AB - 1) % VB == 0) begin
                k = (n - AB - 1) / VB - 1;
                c.instr = 8'h01;
                c.addr  = AW'(field(0, AB) + 64'(k));
                c.val   = VW'(field(n - VB, VB));
                mdl_issue(c);
                if (k + 1 == m_words) m_busy = 0;
            end
        end
    endfunction

    function automatic void mdl_gap(input int gap);
        if (m_busy && gap >= T) begin
            m_busy = 0;
            exp_err++;
        end
    endfunction

    task automatic send(input logic [7:0] b, input int gap);
        mdl_byte(b);
        spi_rx_byte  = b;
        spi_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        spi_rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        mdl_gap(gap);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        mdl_gap(n);
    endtask

    // Compare every observed pulse against the model's expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check("cmd_extra", 64'(exp_q.size()), 64'd1);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    check("cmd_instr", 64'(instruction_bus), 64'(e.instr));
                    check("cmd_addr", 64'(address_bus), 64'(e.addr));
                    check("cmd_val", 64'(value_bus), 64'(e.val));
                end
            end
            if (tx_load) begin
                if (tx_q.size() == 0) begin
                    check("tx_extra", 64'(tx_q.size()), 64'd1);
                end else begin
                    logic [7:0] t;
                    t = tx_q.pop_front();
                    check("tx_byte", 64'(tx_byte), 64'(t));
                end
            end
            if (error) err_seen++;
        end
    end

    task automatic send_write(input logic [AW-1:0] a, input logic [VW-1:0] v,
                              input int gap);
        logic [AW-1:0] aa;
        logic [VW-1:0] vv;
        aa = a;
        vv = v;
        send(8'h01, gap);
        for (int i = AB - 1; i >= 0; i--) send(aa[i*8 +: 8], gap);
        for (int i = VB - 1; i >= 0; i--) send(vv[i*8 +: 8], gap);
    endtask

    task automatic random_frame();
        int kind;
        int nw;
        int len;
        int cut;
        logic [7:0] fb[$];
        kind = $urandom_range(0, 7);
        case (kind)
            0, 1, 2, 7: begin
                fb.push_back(8'($urandom_range(1, 3)));
                for (int i = 0; i < AB; i++) fb.push_back(8'($urandom));
                if (fb[0] == 8'h03) begin
                    nw = $urandom_range(1, 3);
                    fb.push_back(8'(nw));
                    for (int i = 0; i < nw * VB; i++)
                        fb.push_back(8'($urandom));
                end else if (fb[0] == 8'h01) begin
                    for (int i = 0; i < VB; i++) fb.push_back(8'($urandom));
                end
                len = fb.size();
                cut = (kind == 7) ? $urandom_range(1, len - 1) : len;
                for (int i = 0; i < cut; i++) begin
                    if (i == cut - 1 && kind == 7)
                        send(fb[i], T + $urandom_range(0, 4));
                    else
                        send(fb[i], $urandom_range(0, 3));
                end
            end
            3, 4: send(8'h04, $urandom_range(0, 2));
            5: send(8'h05, $urandom_range(0, 2));
            default: begin
                logic [7:0] u;
                u = 8'($urandom_range(6, 255));
                if ($urandom_range(0, 7) == 0) u = 8'h00;
                send(u, $urandom_range(0, 3));
            end
        endcase
    endtask

    initial begin
        rst_n        = 1'b0;
        spi_rx_valid = 1'b0;
        spi_rx_byte  = 8'h00;
        #1;
        check("rst_instr", 64'(instruction_bus), 64'd0);
        check("rst_addr", 64'(address_bus), 64'd0);
        check("rst_val", 64'(value_bus), 64'd0);
        check("rst_cmd", 64'(cmd_valid), 64'd0);
        check("rst_tx", 64'(tx_byte), 64'd0);
        check("rst_txl", 64'(tx_load), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(error), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        send(8'h05, 3);

        send_write(24'h123456, 32'hDEADBEEF, 0);
        check("wr_lat_cmd", 64'(cmd_valid), 64'd1);
        check("wr_busy", 64'(busy), 64'd0);
        idle(2);
        check("wr_addr", 64'(address_bus), 64'h123456);
        check("wr_val", 64'(value_bus), 64'hDEADBEEF);
        check("wr_instr", 64'(instruction_bus), 64'h01);

        send(8'h05, 0);
        check("rep_lat", 64'(cmd_valid), 64'd1);
        idle(2);

        send(8'h02, 1);
        send(8'h00, 1);
        send(8'h00, 1);
        send(8'h10, 0);
        check("rd_val0", 64'(value_bus), 64'd0);
        for (int i = 0; i < 5; i++) send(8'h04, (i == 4) ? 0 : 1);
        check("tx_lat", 64'(tx_load), 64'd1);
        idle(2);

        send(8'h02, 0);
        send(8'hAB, 0);
        send(8'hCD, 0);
        send(8'hEF, 0);
        send(8'h04, 0);
        send(8'h04, 2);

        send(8'h03, 0);
        send(8'hFF, 0);
        send(8'hFF, 0);
        send(8'hFF, 0);
        send(8'h02, 0);
        for (int w = 1; w <= 2; w++)
            for (int i = VB - 1; i >= 0; i--)
                send(8'(w >> (8 * i)), 0);
        check("st_busy", 64'(busy), 64'd0);
        idle(2);
        check("st_wrap", 64'(address_bus), 64'h000000);

        send(8'h01, 0);
        send(8'h12, 0);
        send(8'h34, T);
        check("tmo_err", 64'(error), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        idle(2);
        check("tmo_bus", 64'(address_bus), 64'h000000);

        send(8'h01, 0);
        send(8'h12, T - 1);
        check("tmo_edge_busy", 64'(busy), 64'd1);
        send(8'h34, 0);
        send(8'h56, 0);
        send(8'h0A, 0);
        send(8'h0B, 0);
        send(8'h0C, 0);
        send(8'h0D, 2);

        send_write(24'hA5A5A5, 32'h01234567, 1);
        idle(2);

        send(8'h07, 0);
        check("unk_err", 64'(error), 64'd1);
        check("unk_busy", 64'(busy), 64'd0);
        idle(2);

        send(8'h03, 0);
        send(8'h00, 0);
        send(8'h10, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        for (int w = 0; w < 256; w++)
            for (int i = VB - 1; i >= 0; i--)
                send(8'(w * 7 + i), 0);
        check("st256_busy", 64'(busy), 64'd0);
        idle(2);

        for (int n = 0; n < 200; n++) random_frame();
        idle(T + 4);

        send(8'h01, 0);
        for (int i = 0; i < AB; i++) send(8'($urandom), 0);
        send(8'h11, 0);
        send(8'h22, 0);
        rst_n = 1'b0;
        #1;
        check("mrst_instr", 64'(instruction_bus), 64'd0);
        check("mrst_addr", 64'(address_bus), 64'd0);
        check("mrst_val", 64'(value_bus), 64'd0);
        check("mrst_cmd", 64'(cmd_valid), 64'd0);
        check("mrst_tx", 64'(tx_byte), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_err", 64'(error), 64'd0);
        m_busy = 0;
        m_have = 0;
        m_buf  = '0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        send(8'h05, 2);
        send(8'h04, 2);
        send(8'h04, 2);
        send_write(24'h00BEEF, 32'h55AA55AA, 0);
        idle(T + 4);

        check("cmd_left", 64'(exp_q.size()), 64'd0);
        check("tx_left", 64'(tx_q.size()), 64'd0);
        check("err_cnt", 64'(err_seen), 64'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
